// File: rtl/proc_param.sv
// proc_param: multi-cycle processor with eight DATA_W-bit registers, an A/G ALU path,
// a 10-bit instruction register and a shared bus (busWire).
// Each instruction takes T0 (fetch) then T1, or T1..T3 for ALU ops.
// Optional feature: define PROC_MVNZ_EN to make opcode 8 a conditional move (mvnz);
// when it is undefined, opcode 8 is a nop.
module proc_param #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [DATA_W-1:0] Din,
  output logic              done,
  output logic              busy,
  output logic [1:0]        step,
  output logic [DATA_W-1:0] busWire
);

  typedef enum logic [1:0] {
    StT0 = 2'd0,
    StT1 = 2'd1,
    StT2 = 2'd2,
    StT3 = 2'd3
  } step_e;

  localparam logic [3:0] OpMv  = 4'd0;
  localparam logic [3:0] OpMvi = 4'd1;
  localparam logic [3:0] OpAdd = 4'd2;
  localparam logic [3:0] OpSub = 4'd3;
  localparam logic [3:0] OpOr  = 4'd4;
  localparam logic [3:0] OpSlt = 4'd5;
  localparam logic [3:0] OpSll = 4'd6;
  localparam logic [3:0] OpSrl = 4'd7;
  localparam logic [3:0] OpAnd = 4'd9;
  localparam logic [3:0] OpXor = 4'd10;
`ifdef PROC_MVNZ_EN
  localparam logic [3:0] OpMvnz = 4'd8;
`endif

  step_e             step_q, step_d;
  logic [DATA_W-1:0] regs_q [8];
  logic [DATA_W-1:0] a_q, g_q;
  logic [9:0]        ir_q;

  logic [3:0]        opcode;
  logic [2:0]        xsel, ysel;
  logic [DATA_W-1:0] rx, ry, bus, alu_res;
  logic              is_alu, done_int, ir_we, reg_we, a_we, g_we;
  logic [63:0]       sh_amt;
  logic              sh_zero;

  assign opcode = ir_q[9:6];
  assign xsel   = ir_q[5:3];
  assign ysel   = ir_q[2:0];
  assign rx     = regs_q[xsel];
  assign ry     = regs_q[ysel];

`ifdef PROC_MVNZ_EN
  logic g_nz;
  assign g_nz = |g_q;
`endif

  // Shift amounts are unsigned and anything >= DATA_W clears the result
  assign sh_amt  = 64'(ry);
  assign sh_zero = sh_amt >= 64'(DATA_W);

  // Classify opcodes that take the four-step A/G path
  always_comb begin
    is_alu = 1'b0;
    case (opcode)
      OpAdd, OpSub, OpOr, OpSlt, OpSll, OpSrl, OpAnd, OpXor: is_alu = 1'b1;
      default: is_alu = 1'b0;
    endcase
  end

  // ALU: A op Ry, evaluated during T2 and captured into G
  always_comb begin
    alu_res = '0;
    case (opcode)
      OpAdd:   alu_res = a_q + ry;
      OpSub:   alu_res = a_q - ry;
      OpOr:    alu_res = a_q | ry;
      OpSlt:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(ry))};
      OpSll:   alu_res = sh_zero ? '0 : (a_q << sh_amt[5:0]);
      OpSrl:   alu_res = sh_zero ? '0 : (a_q >> sh_amt[5:0]);
      OpAnd:   alu_res = a_q & ry;
      OpXor:   alu_res = a_q ^ ry;
      default: alu_res = '0;
    endcase
  end

  // Step sequencing, bus source select and write enables
  always_comb begin
    step_d   = step_q;
    bus      = '0;
    done_int = 1'b0;
    ir_we    = 1'b0;
    reg_we   = 1'b0;
    a_we     = 1'b0;
    g_we     = 1'b0;
    unique case (step_q)
      StT0: begin
        bus = Din;
        if (run) begin
          ir_we  = 1'b1;
          step_d = StT1;
        end
      end
      StT1: begin
        if (is_alu) begin
          bus    = rx;
          a_we   = 1'b1;
          step_d = StT2;
        end else begin
          done_int = 1'b1;
          step_d   = StT0;
          case (opcode)
            OpMv: begin
              bus    = ry;
              reg_we = 1'b1;
            end
            OpMvi: begin
              bus    = Din;
              reg_we = 1'b1;
            end
`ifdef PROC_MVNZ_EN
            OpMvnz: begin
              bus    = ry;
              reg_we = g_nz;
            end
`endif
            default: bus = '0;
          endcase
        end
      end
      StT2: begin
        bus    = ry;
        g_we   = 1'b1;
        step_d = StT3;
      end
      StT3: begin
        bus      = g_q;
        reg_we   = 1'b1;
        done_int = 1'b1;
        step_d   = StT0;
      end
    endcase
  end

  // State, IR, A, G and register file; reset clears everything and aborts any instruction
  always_ff @(posedge clock) begin
    if (reset) begin
      step_q <= StT0;
      ir_q   <= '0;
      a_q    <= '0;
      g_q    <= '0;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      step_q <= step_d;
      if (ir_we) begin
        ir_q <= Din[DATA_W-1 -: 10];
      end
      if (a_we) begin
        a_q <= bus;
      end
      if (g_we) begin
        g_q <= alu_res;
      end
      if (reg_we) begin
        regs_q[xsel] <= bus;
      end
    end
  end

  // Status outputs read as idle while reset is held
  assign busWire = bus;
  assign done    = done_int & ~reset;
  assign busy    = (step_q != StT0) & ~reset;
  assign step    = reset ? 2'b00 : step_q;

endmodule

// File: tb/tb_proc_param.sv
// Self-checking bench for proc_param: directed instruction sequences plus a randomized
// instruction stream checked against a register-level model of the instruction set.
module tb_proc_param;
  localparam int unsigned W = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic         run;
  logic [W-1:0] Din;
  logic         done;
  logic         busy;
  logic [1:0]   step;
  logic [W-1:0] busWire;

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural model state
  logic [W-1:0] mregs [8];
  logic [W-1:0] mg;

  proc_param #(.DATA_W(W)) dut (
    .clock  (clock),
    .reset  (reset),
    .run    (run),
    .Din    (Din),
    .done   (done),
    .busy   (busy),
    .step   (step),
    .busWire(busWire)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // 0 mv, 1 mvi, 2 alu, 3 mvnz, 4 nop
  function automatic int kind_of(input logic [3:0] op);
    case (op)
      4'd0: return 0;
      4'd1: return 1;
      4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10: return 2;
`ifdef PROC_MVNZ_EN
      4'd8: return 3;
`endif
      default: return 4;
    endcase
  endfunction

  function automatic logic [W-1:0] alu_model(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    case (op)
      4'd2: return a + b;
      4'd3: return a - b;
      4'd4: return a | b;
      4'd5: return ($signed(a) < $signed(b)) ? W'(1) : '0;
      4'd6: return (32'(b) >= W) ? '0 : (a << b);
      4'd7: return (32'(b) >= W) ? '0 : (a >> b);
      4'd9: return a & b;
      4'd10: return a ^ b;
      default: return '0;
    endcase
  endfunction

  // Run one instruction from T0, checking step/busy/done/busWire every cycle
  task automatic exec(input logic [3:0] op, input logic [2:0] x, input logic [2:0] y,
                      input logic [W-1:0] imm);
    logic [W-1:0] word, rx, ry, res, exp_bus;
    int           kind, last;
    logic         chk_bus;
    rx   = mregs[x];
    ry   = mregs[y];
    res  = alu_model(op, rx, ry);
    kind = kind_of(op);
    last = (kind == 2) ? 3 : 1;
    word = W'($urandom);
    word[W-1 -: 10] = {op, x, y};
    run = 1'b1;
    Din = word;
    @(negedge clock);
    n_tests++;
    if (step !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || busWire !== word) begin
      n_fail++;
      $display("FAIL exec_t0 op=%0d x=%0d y=%0d: step=%0d busy=%b done=%b bus=%h, want 0/0/0 bus=%h",
               op, x, y, step, busy, done, busWire, word);
    end
    tick;
    for (int k = 1; k <= last; k++) begin
      run     = 1'($urandom_range(0, 1));
      Din     = (k == 1) ? imm : W'($urandom);
      chk_bus = 1'b1;
      exp_bus = res;
      if (k == 1) begin
        case (kind)
          0, 3: exp_bus = ry;
          1: exp_bus = imm;
          2: exp_bus = rx;
          default: chk_bus = 1'b0;
        endcase
      end else if (k == 2) begin
        exp_bus = ry;
      end
      @(negedge clock);
      n_tests++;
      if (step !== 2'(k) || busy !== 1'b1 || done !== (k == last) ||
          (chk_bus && busWire !== exp_bus)) begin
        n_fail++;
        $display("FAIL exec_t%0d op=%0d x=%0d y=%0d: step=%0d busy=%b done=%b bus=%h, want step=%0d busy=1 done=%b bus=%h",
                 k, op, x, y, step, busy, done, busWire, k, (k == last), exp_bus);
      end
      tick;
    end
    run = 1'b0;
    case (kind)
      0: mregs[x] = ry;
      1: mregs[x] = imm;
      2: begin
        mregs[x] = res;
        mg       = res;
      end
      3: if (mg != '0) mregs[x] = ry;
      default: ;
    endcase
  endtask

  // Read a register via mv Rk,Rk (no checks, value returned to caller)
  task automatic read_reg(input logic [2:0] k, output logic [W-1:0] val);
    run = 1'b1;
    Din = {4'd0, k, k, 6'd0};
    tick;
    run = 1'b0;
    @(negedge clock);
    val = busWire;
    tick;
  endtask

  task automatic readall;
    for (int k = 0; k < 8; k++) exec(4'd0, 3'(k), 3'(k), W'($urandom));
  endtask

  task automatic test_reset;
    reset = 1'b1;
    run   = 1'b1;
    tick;
    for (int i = 0; i < 3; i++) begin
      Din = W'($urandom);
      @(negedge clock);
      n_tests++;
      if (step !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: step=%0d busy=%b done=%b, want 0/0/0", step, busy, done);
      end
      tick;
    end
    reset = 1'b0;
    run   = 1'b0;
    for (int k = 0; k < 8; k++) mregs[k] = '0;
    mg = '0;
    readall;
  endtask

  task automatic test_add;
    logic [W-1:0] v;
    exec(4'd1, 3'd0, 3'd0, 16'd5);
    exec(4'd1, 3'd1, 3'd0, 16'd3);
    exec(4'd2, 3'd0, 3'd1, '0);
    @(negedge clock);
    n_tests++;
    if (step !== 2'd0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL add_return: step=%0d done=%b, want 0/0", step, done);
    end
    tick;
    read_reg(3'd0, v);
    n_tests++;
    if (v !== 16'd8) begin
      n_fail++;
      $display("FAIL add_result: R0=%h, want 0008", v);
    end
  endtask

  task automatic test_slt_sub;
    logic [W-1:0] v;
    exec(4'd1, 3'd2, 3'd0, 16'h8000);
    exec(4'd1, 3'd3, 3'd0, 16'd1);
    exec(4'd5, 3'd2, 3'd3, '0);
    read_reg(3'd2, v);
    n_tests++;
    if (v !== 16'd1) begin
      n_fail++;
      $display("FAIL slt_signed: R2=%h, want 0001", v);
    end
    exec(4'd3, 3'd3, 3'd2, '0);
    read_reg(3'd3, v);
    n_tests++;
    if (v !== 16'd0) begin
      n_fail++;
      $display("FAIL sub_zero: R3=%h, want 0000", v);
    end
  endtask

  task automatic test_shift;
    logic [W-1:0] v;
    exec(4'd1, 3'd4, 3'd0, 16'h00F0);
    exec(4'd1, 3'd5, 3'd0, 16'd20);
    exec(4'd6, 3'd4, 3'd5, '0);
    read_reg(3'd4, v);
    n_tests++;
    if (v !== 16'd0) begin
      n_fail++;
      $display("FAIL sll_wide: R4=%h, want 0000", v);
    end
    exec(4'd1, 3'd4, 3'd0, 16'h00F0);
    exec(4'd1, 3'd5, 3'd0, 16'd4);
    exec(4'd7, 3'd4, 3'd5, '0);
    read_reg(3'd4, v);
    n_tests++;
    if (v !== 16'h000F) begin
      n_fail++;
      $display("FAIL srl_4: R4=%h, want 000f", v);
    end
  endtask

  task automatic test_xeqy;
    logic [W-1:0] v;
    exec(4'd1, 3'd7, 3'd0, 16'h1234);
    exec(4'd2, 3'd7, 3'd7, '0);
    read_reg(3'd7, v);
    n_tests++;
    if (v !== 16'h2468) begin
      n_fail++;
      $display("FAIL add_same_reg: R7=%h, want 2468", v);
    end
  endtask

  task automatic test_mvnz;
    logic [W-1:0] v, want;
    exec(4'd1, 3'd0, 3'd0, 16'h00AA);
    exec(4'd1, 3'd6, 3'd0, 16'h0055);
    exec(4'd1, 3'd1, 3'd0, 16'h0007);
    exec(4'd3, 3'd1, 3'd1, '0);
    exec(4'd8, 3'd6, 3'd0, '0);
    read_reg(3'd6, v);
    n_tests++;
    if (v !== 16'h0055) begin
      n_fail++;
      $display("FAIL mvnz_gzero: R6=%h, want 0055", v);
    end
    exec(4'd2, 3'd1, 3'd0, '0);
    exec(4'd8, 3'd6, 3'd0, '0);
    read_reg(3'd6, v);
`ifdef PROC_MVNZ_EN
    want = 16'h00AA;
`else
    want = 16'h0055;
`endif
    n_tests++;
    if (v !== want) begin
      n_fail++;
      $display("FAIL mvnz_gnonzero: R6=%h, want %h", v, want);
    end
  endtask

  task automatic test_idle;
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      Din = W'($urandom);
      @(negedge clock);
      n_tests++;
      if (step !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || busWire !== Din) begin
        n_fail++;
        $display("FAIL idle_t0: step=%0d busy=%b done=%b bus=%h, want 0/0/0 bus=%h",
                 step, busy, done, busWire, Din);
      end
      tick;
    end
    readall;
    exec(4'd13, 3'($urandom), 3'($urandom), W'($urandom));
    readall;
  endtask

  task automatic test_random;
    logic [3:0]   op;
    logic [2:0]   x, y;
    logic [W-1:0] imm;
    for (int i = 0; i < 300; i++) begin
      op  = 4'($urandom_range(0, 15));
      x   = 3'($urandom);
      y   = 3'($urandom);
      imm = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        run = 1'b0;
        Din = W'($urandom);
        @(negedge clock);
        n_tests++;
        if (step !== 2'd0 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_gap: step=%0d busy=%b, want 0/0", step, busy);
        end
        tick;
      end
      exec(op, x, y, imm);
    end
    readall;
  endtask

  task automatic test_reset_abort;
    exec(4'd1, 3'd0, 3'd0, W'($urandom) | W'(1));
    exec(4'd1, 3'd1, 3'd0, W'($urandom) | W'(1));
    run = 1'b1;
    Din = {4'd2, 3'd0, 3'd1, 6'd0};
    tick;
    run = 1'b0;
    tick;
    @(negedge clock);
    n_tests++;
    if (step !== 2'd2 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_in_t2: step=%0d done=%b, want 2/0", step, done);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (step !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_reset_out: step=%0d busy=%b done=%b, want 0/0/0", step, busy, done);
    end
    tick;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_tests++;
      if (step !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_after: step=%0d busy=%b done=%b, want 0/0/0", step, busy, done);
      end
      tick;
    end
    for (int k = 0; k < 8; k++) mregs[k] = '0;
    mg = '0;
    readall;
  endtask

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    Din   = '0;
    test_reset;
    test_add;
    test_slt_sub;
    test_shift;
    test_xeqy;
    test_mvnz;
    test_idle;
    test_random;
    test_reset_abort;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_param.md
PROC_PARAM -- requirements
Module: proc_param

Interface
REQ-001 Parameter: DATA_W, default 16, bus/register/ALU width in bits; legal range 10..64.
REQ-002 Port: clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: run  input  1  start request; sampled only in step 0.
REQ-005 Port: Din  input  DATA_W  instruction word (step 0) or immediate (mvi step 1).
REQ-006 Port: done  output  1  high during the final step of an instruction.
REQ-007 Port: busy  output  1  high whenever step != 0.
REQ-008 Port: step  output  2  current step counter value.
REQ-009 Port: busWire  output  DATA_W  shared datapath bus.

Function
REQ-010 State: 4-step counter T0..T3, eight DATA_W registers R0..R7, A, G, 10-bit IR; instruction = Din[DATA_W-1 -: 10] = {opcode[3:0], X[2:0], Y[2:0]}.
REQ-011 T0: IR loads and counter advances to T1 only if run=1; run=0 holds T0, busWire = Din.
REQ-012 Opcodes: 0 mv, 1 mvi, 2 add, 3 sub, 4 or, 5 slt, 6 sll, 7 srl, 8 mvnz, 9 and, 10 xor, 11..15 nop.
REQ-013 mv: T1 busWire=Ry, Rx<=Ry, done=1; latency 2 cycles from run.
REQ-014 mvi: T1 busWire=Din (full DATA_W), Rx<=Din, done=1.
REQ-015 ALU ops: T1 busWire=Rx, A<=Rx; T2 busWire=Ry, G<=f(A,Ry); T3 busWire=G, Rx<=G, done=1; latency 4 cycles.
REQ-016 add/sub modulo 2^DATA_W, no carry/overflow output.
REQ-017 slt: G = 1 if signed(A) < signed(Ry) else 0, zero-extended.
REQ-018 sll/srl: logical shift of A by unsigned Ry; Ry >= DATA_W yields 0.
REQ-019 nop: T1 done=1, no register/A/G write.
REQ-020 done pulse forces counter to T0 on the next edge; done=0 in all other cycles.
REQ-021 X==Y legal: ALU reads old Rx in T1 and T2; Rx updated only in T3.
REQ-022 Only one bus source per cycle; at most one of R0..R7/A/G/IR written per edge.
REQ-023 G holds value of most recent completed ALU op; mv/mvi/nop/mvnz leave G unchanged.

Reset
REQ-024 reset=1 at an edge: counter->T0, R0..R7, A, G, IR -> 0, regardless of current step.
REQ-025 While reset=1: done=0, busy=0, step=0, no register write; run ignored.
REQ-026 Reset mid-instruction aborts it; no partial write-back after reset deasserts.

Configuration
REQ-027 Macro PROC_MVNZ_EN defined: opcode 8 = mvnz; T1 busWire=Ry, Rx<=Ry only if G != 0, done=1 in T1 either way.
REQ-028 PROC_MVNZ_EN undefined: opcode 8 behaves exactly as nop (REQ-019); no G-zero detect logic.

Verification
REQ-029 Reset, mvi R0,#5 then mvi R1,#3, add R0,R1 -> R0=8, done high in T3, step returns 0 next cycle.
REQ-030 DATA_W=16: mvi R2,#0x8000, mvi R3,#1, slt R2,R3 -> R2=1; sub R3,R2 wrap: R3=0 from 1-1.
REQ-031 mvi R4,#0x00F0, mvi R5,#20, sll R4,R5 -> R4=0; srl with R5=4 -> R4=0x000F.
REQ-032 With PROC_MVNZ_EN: G=0 after sub, mvnz R6,R0 -> R6 unchanged; G!=0 after add -> R6=R0; without macro R6 unchanged both cases.
REQ-033 Assert reset in T2 of add R0,R1 -> next cycle step=0, all regs 0, done never asserted for aborted op.
REQ-034 run=0 held 5 cycles in T0 -> step stays 0, busy=0, no register changes; opcode 13 -> done in T1, state unchanged.
